// File: rtl/match_reporter_if.sv
// Record stream from match_reporter to the host/DMA consumer.
// A record transfers on a clock edge where m_valid and m_ready are both high.
interface match_reporter_if #(
  parameter int PKT_ID_W  = 16,
  parameter int RULE_ID_W = 6
);
  logic                 m_valid;
  logic                 m_ready;
  logic [PKT_ID_W-1:0]  m_pkt_id;
  logic [RULE_ID_W-1:0] m_rule_id;
  logic                 m_last;
  logic                 m_none;

  modport master (
    output m_valid, m_pkt_id, m_rule_id, m_last, m_none,
    input  m_ready
  );

  modport slave (
    input  m_valid, m_pkt_id, m_rule_id, m_last, m_none,
    output m_ready
  );
endinterface

// File: rtl/match_reporter.sv
// Snapshots engine match bits at end of packet and serialises them into a record FIFO.
// MATCH_REPORTER_NOMATCH_EN: when defined, a packet with no matches emits one "none" record.
module match_reporter #(
  parameter int NUM_ENGINES = 64,
  parameter int RULE_ID_W   = 6,
  parameter int PKT_ID_W    = 16,
  parameter int FIFO_DEPTH  = 16,
  parameter int CNT_W       = 16
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   en,
  input  logic                   sod,
  input  logic                   eod,
  input  logic [PKT_ID_W-1:0]    pkt_id,
  input  logic [NUM_ENGINES-1:0] match_in,
  output logic                   busy,
  match_reporter_if.master       m,
  output logic [CNT_W-1:0]       drop_cnt,
  output logic [1:0]             dbg_state
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [PTR_W:0] DEPTH_C = (PTR_W+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_SCAN = 2'd2
  } state_t;

`ifdef MATCH_REPORTER_NOMATCH_EN
  typedef struct packed {
    logic [PKT_ID_W-1:0]  pkt_id;
    logic [RULE_ID_W-1:0] rule_id;
    logic                 last;
    logic                 none;
  } rec_t;
`else
  typedef struct packed {
    logic [PKT_ID_W-1:0]  pkt_id;
    logic [RULE_ID_W-1:0] rule_id;
    logic                 last;
  } rec_t;
`endif

  state_t                 state_q, state_d;
  logic [PKT_ID_W-1:0]    tag_q;
  logic [NUM_ENGINES-1:0] snap_q, snap_d, snap_rest;
  logic [RULE_ID_W-1:0]   low_idx;
  logic                   capture, collide;
  logic                   push_req, push_room, push, pop;
  rec_t                   push_rec, head;

  rec_t                   mem [FIFO_DEPTH];
  logic [PTR_W-1:0]       wr_ptr_q, rd_ptr_q;
  logic [PTR_W:0]         count_q;
  logic                   valid;

  // sod only matters to the engines; the collision rule is keyed on eod alone.
  logic unused_sod;
  assign unused_sod = sod;

  assign busy      = (state_q != ST_IDLE);
  assign dbg_state = state_q;
  assign capture   = en & eod & ~busy;
  assign collide   = en & eod & busy;
  assign snap_rest = snap_q & (snap_q - NUM_ENGINES'(1));

  always_comb begin
    low_idx = '0;
    for (int i = NUM_ENGINES - 1; i >= 0; i--) begin
      if (snap_q[i]) low_idx = RULE_ID_W'(i);
    end
  end

  always_comb begin
    state_d          = state_q;
    snap_d           = snap_q;
    push_req         = 1'b0;
    push_rec         = '0;
    push_rec.pkt_id  = tag_q;
    push_rec.rule_id = low_idx;
    push_rec.last    = (snap_rest == '0);
    case (state_q)
      ST_IDLE: begin
        if (capture) state_d = ST_WAIT;
      end
      ST_WAIT: begin
        // Engines registered the last byte on the capture edge; their outputs are valid now.
        snap_d  = match_in;
        state_d = ST_SCAN;
      end
      ST_SCAN: begin
        if (snap_q != '0) begin
          push_req = 1'b1;
          if (push_room) begin
            snap_d = snap_rest;
            if (snap_rest == '0) state_d = ST_IDLE;
          end
        end else begin
`ifdef MATCH_REPORTER_NOMATCH_EN
          push_req         = 1'b1;
          push_rec.rule_id = '0;
          push_rec.last    = 1'b1;
          push_rec.none    = 1'b1;
          if (push_room) state_d = ST_IDLE;
`else
          state_d = ST_IDLE;
`endif
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= ST_IDLE;
      snap_q   <= '0;
      tag_q    <= '0;
      drop_cnt <= '0;
    end else begin
      state_q <= state_d;
      snap_q  <= snap_d;
      if (capture) tag_q <= pkt_id;
      if (collide && drop_cnt != '1) drop_cnt <= drop_cnt + CNT_W'(1);
    end
  end

  // Record FIFO: no fall-through; a pop frees a slot for a same-cycle push.
  assign valid     = (count_q != '0);
  assign pop       = valid & m.m_ready;
  assign push_room = (count_q != DEPTH_C) | pop;
  assign push      = push_req & push_room;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + (PTR_W+1)'(1);
        2'b01:   count_q <= count_q - (PTR_W+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= push_rec;
  end

  assign head        = mem[rd_ptr_q];
  assign m.m_valid   = valid;
  assign m.m_pkt_id  = valid ? head.pkt_id  : '0;
  assign m.m_rule_id = valid ? head.rule_id : '0;
  assign m.m_last    = valid ? head.last    : 1'b0;
`ifdef MATCH_REPORTER_NOMATCH_EN
  assign m.m_none    = valid ? head.none    : 1'b0;
`else
  assign m.m_none    = 1'b0;
`endif

endmodule

// File: tb/tb_match_reporter.sv
// Directed bench for match_reporter: latency, ordering, backpressure, collisions, reset.
module tb_match_reporter;
  localparam int PW = 16;
  localparam int RW = 6;
  localparam int NE = 64;
  localparam int CW = 2;

  logic          clk = 1'b0;
  logic          resetn;
  logic          en, sod, eod;
  logic [PW-1:0] pkt_id;
  logic [NE-1:0] match_in;
  logic          busy;
  logic [CW-1:0] drop_cnt;
  logic [1:0]    dbg_state;

  match_reporter_if #(.PKT_ID_W(PW), .RULE_ID_W(RW)) mif ();

  match_reporter #(
    .NUM_ENGINES(NE), .RULE_ID_W(RW), .PKT_ID_W(PW), .FIFO_DEPTH(16), .CNT_W(CW)
  ) dut (
    .clk(clk), .resetn(resetn), .en(en), .sod(sod), .eod(eod),
    .pkt_id(pkt_id), .match_in(match_in), .busy(busy), .m(mif.master),
    .drop_cnt(drop_cnt), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  logic [PW+RW+1:0] exp_q[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [PW+RW+1:0] mk_rec(input logic [PW-1:0] id, input logic [RW-1:0] r,
                                               input logic last, input logic none);
    return {id, r, last, none};
  endfunction

  // scoreboard: every accepted record must match the head of exp_q
  always @(negedge clk) begin
    if (resetn && mif.m_valid && mif.m_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_rec", {mif.m_pkt_id, mif.m_rule_id, mif.m_last, mif.m_none}, 0);
      end else begin
        check("rec", {mif.m_pkt_id, mif.m_rule_id, mif.m_last, mif.m_none}, exp_q.pop_front());
      end
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_pkt(input logic [PW-1:0] id, input logic [NE-1:0] bits);
    en = 1'b1; eod = 1'b1; pkt_id = id; match_in = bits;
    tick();
    en = 1'b0; eod = 1'b0;
  endtask

  task automatic expect_bits(input logic [PW-1:0] id, input logic [NE-1:0] bits);
    int hi;
    hi = -1;
    for (int i = 0; i < NE; i++) if (bits[i]) hi = i;
    for (int i = 0; i < NE; i++) if (bits[i]) exp_q.push_back(mk_rec(id, RW'(i), i == hi, 1'b0));
  endtask

  task automatic wait_idle(input string tag, input int budget);
    logic done;
    done = 1'b0;
    for (int c = 0; c < budget && !done; c++) begin
      tick();
      if (!busy && !mif.m_valid && exp_q.size() == 0) done = 1'b1;
    end
    check(tag, done, 1);
  endtask

  initial begin
    logic [NE-1:0] bits;
    resetn = 1'b0; en = 1'b0; sod = 1'b0; eod = 1'b0; pkt_id = '0; match_in = '0;
    mif.m_ready = 1'b1;
    repeat (3) tick();
    resetn = 1'b1;
    tick();

    check("rst_valid", mif.m_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_drop", drop_cnt, 0);
    check("rst_state", dbg_state, 0);
    check("rst_pkt", mif.m_pkt_id, 0);

    // single match, engine bit appears one clk after eod
    expect_bits(16'h1234, 64'h20);
    send_pkt(16'h1234, '0);
    match_in = 64'h20;
    check("single_busy_e0", busy, 1);
    check("single_valid_e0", mif.m_valid, 0);
    tick();
    check("single_valid_e1", mif.m_valid, 0);
    tick();
    check("single_valid_e2", mif.m_valid, 1);
    wait_idle("single_idle", 50);

    // multi match: 0, 17, 63 back to back
    bits = '0; bits[0] = 1'b1; bits[17] = 1'b1; bits[63] = 1'b1;
    expect_bits(16'h00AB, bits);
    send_pkt(16'h00AB, bits);
    tick(); tick();
    check("multi_valid_e2", mif.m_valid, 1);
    tick();
    check("multi_busy_e3", busy, 1);
    check("multi_valid_e3", mif.m_valid, 1);
    tick();
    check("multi_busy_e4", busy, 0);
    wait_idle("multi_idle", 50);

    // backpressure: 20 records into a 16-entry FIFO
    bits = '0;
    for (int i = 0; i < 20; i++) bits[i*3] = 1'b1;
    mif.m_ready = 1'b0;
    expect_bits(16'h0BBB, bits);
    send_pkt(16'h0BBB, bits);
    repeat (40) tick();
    check("bp_busy", busy, 1);
    check("bp_state", dbg_state, 2);
    check("bp_head_rule", mif.m_rule_id, 0);
    check("bp_pending", exp_q.size(), 20);
    mif.m_ready = 1'b1;
    wait_idle("bp_idle", 100);
    check("bp_drained", exp_q.size(), 0);

    // collision one cycle into a 4-match scan
    bits = '0; bits[1] = 1'b1; bits[2] = 1'b1; bits[3] = 1'b1; bits[40] = 1'b1;
    expect_bits(16'h000A, bits);
    send_pkt(16'h000A, bits);
    send_pkt(16'h000B, bits);
    check("coll_drop1", drop_cnt, 1);
    wait_idle("coll_idle", 50);

    // saturation of the drop counter (all-ones = 3 here)
    expect_bits(16'h000C, 64'hFF00);
    send_pkt(16'h000C, 64'hFF00);
    en = 1'b1; eod = 1'b1; pkt_id = 16'h000D;
    tick();
    check("sat_drop2", drop_cnt, 2);
    tick();
    check("sat_drop3", drop_cnt, 3);
    tick();
    check("sat_hold", drop_cnt, 3);
    en = 1'b0; eod = 1'b0;
    wait_idle("sat_idle", 50);

    // no match
`ifdef MATCH_REPORTER_NOMATCH_EN
    exp_q.push_back(mk_rec(16'h0077, '0, 1'b1, 1'b1));
`endif
    send_pkt(16'h0077, '0);
    check("nm_busy_e0", busy, 1);
    tick();
    check("nm_busy_e1", busy, 1);
    tick();
    check("nm_busy_e2", busy, 0);
`ifdef MATCH_REPORTER_NOMATCH_EN
    check("nm_valid_e2", mif.m_valid, 1);
`else
    check("nm_valid_e2", mif.m_valid, 0);
`endif
    wait_idle("nm_idle", 20);

    // async reset mid-scan with 3 records queued
    mif.m_ready = 1'b0;
    expect_bits(16'h00EE, 64'hFF);
    send_pkt(16'h00EE, 64'hFF);
    repeat (4) tick();
    check("mr_valid_pre", mif.m_valid, 1);
    check("mr_busy_pre", busy, 1);
    resetn = 1'b0;
    #1;
    check("mr_valid", mif.m_valid, 0);
    check("mr_busy", busy, 0);
    check("mr_drop", drop_cnt, 0);
    exp_q.delete();
    tick();
    resetn = 1'b1;
    mif.m_ready = 1'b1;
    repeat (20) tick();
    check("mr_after_valid", mif.m_valid, 0);
    check("mr_after_busy", busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/match_reporter.md
Name: match_reporter

Overview:
- Sits directly downstream of the bank of payload engines (engine_x_y instances).
- Takes the sticky per-rule "out" bits at end of packet and snapshots them.
- Serialises the set bits into one {packet id, rule id} record per match, lowest rule first, and queues them in a small FIFO.
- The host/DMA side drains the FIFO with a valid/ready handshake.

Parameters:
- NUM_ENGINES, 64, number of engine match inputs; rule id = bit index.
- RULE_ID_W, 6, width of rule id; must satisfy 2**RULE_ID_W >= NUM_ENGINES.
- PKT_ID_W, 16, packet tag width.
- FIFO_DEPTH, 16, record FIFO entries; power of two, >= 2.
- CNT_W, 16, drop counter width.

Ports:
- clk, in, 1, single clock for the whole block.
- resetn, in, 1, asynchronous active-low reset.
- en, in, 1, byte strobe; the same signal that drives engine CE.
- sod, in, 1, start of data; the same pulse that clears the engines.
- eod, in, 1, qualifies the last byte; valid only with en=1.
- pkt_id, in, PKT_ID_W, packet tag; sampled on en&eod.
- match_in, in, NUM_ENGINES, engine out bits; bit i = rule i.
- busy, out, 1, high from capture until the scan completes.
- m_valid, out, 1, FIFO head valid.
- m_ready, in, 1, consumer accept.
- m_pkt_id, out, PKT_ID_W, record packet tag.
- m_rule_id, out, RULE_ID_W, record rule index.
- m_last, out, 1, last record of its packet.
- m_none, out, 1, record means "no rule matched" (see Optional Feature).
- drop_cnt, out, CNT_W, packets lost because busy was high at eod; saturating.

Behaviour:
- Reset: resetn low asynchronously clears FSM to IDLE, snapshot, FIFO pointers/count, busy=0, m_valid=0, drop_cnt=0. m_* data outputs = 0. Reset mid-scan discards all pending records.
- Engine outputs update on the clk edge where en=1. A match on the last byte is therefore visible one clk after the en&eod cycle. The block waits exactly that cycle.
- FSM states: IDLE, WAIT, SCAN.
  - IDLE: on en&eod, latch pkt_id into tag register, go to WAIT, busy=1 from the next cycle.
  - WAIT (1 cycle): latch match_in into snapshot, go to SCAN.
  - SCAN, snapshot nonzero: each cycle with push accepted, push record {tag, idx of lowest set bit, last=(only one bit set), none=0} and clear that bit. When the snapshot becomes zero, go to IDLE and set busy=0.
  - SCAN, snapshot zero on entry: behaviour per Optional Feature, then IDLE.
  - Push not accepted: FSM and snapshot hold.
- Throughput: one record per clk when the FIFO is not full.
- Priority encode covers all NUM_ENGINES bits. Bits at index >= NUM_ENGINES do not exist and are never reported.
- Busy collision: en&eod while busy=1 drops that packet (no snapshot) and increments drop_cnt, saturating at all-ones. sod is ignored by this block apart from that rule.
- FIFO rules:
  - Push accepted when count<FIFO_DEPTH, or when a pop occurs in the same cycle.
  - Pop = m_valid&m_ready.
  - Simultaneous push/pop when full: both occur, count unchanged.
  - Simultaneous push/pop when empty: the record is written, m_valid rises the next cycle (no fall-through).
  - Pointers wrap modulo FIFO_DEPTH.
  - m_* outputs are stable while m_valid=1 and m_ready=0.
- Latency: first record reaches m_valid 3 clk after the en&eod edge (capture, WAIT, push).

Optional Feature:
- Macro: MATCH_REPORTER_NOMATCH_EN.
- Defined: a zero snapshot pushes one record {tag, rule_id=0, last=1, none=1} (one cycle, same stall rules).
- Undefined: a zero snapshot pushes nothing, SCAN exits to IDLE after 1 cycle, and m_none is tied to 0.

Test Plan:
- Reset: resetn pulsed low mid-SCAN with 3 records queued -> m_valid=0, busy=0, drop_cnt=0 immediately; no records after release.
- Single match: match_in bit 5 set, eod with pkt_id=0x1234, m_ready=1 -> one record {0x1234, 5, last=1, none=0}, m_valid 3 clk after eod.
- Multi match: bits 0, 17, 63 set -> records rule 0, 17, 63 on consecutive cycles; last=1 only on 63; busy drops the cycle after the third push.
- Backpressure: 20 bits set, FIFO_DEPTH=16, m_ready=0 -> 16 records held, SCAN stalls with busy=1. Raise m_ready -> all 20 delivered in order, none lost.
- Collision: second en&eod 1 cycle into a 4-match scan -> drop_cnt=1, only the first packet's 4 records emitted. Force drop_cnt to all-ones then collide again -> stays all-ones.
- No match: match_in=0 -> with MATCH_REPORTER_NOMATCH_EN one record {tag, 0, last=1, none=1}; without it no m_valid and busy high for exactly 2 cycles.
